// File: rtl/joypad_uart.sv
// Joypad register (sel/buttons, active-low nibble) fed by an 8N1 UART receiver; optional echo TX under JOYPAD_TX_ECHO_EN.
// Latency: buttons update at the stop-bit sample edge, joy_int one edge later; CPU read data is combinational.
// Backpressure: none; the echo TX keeps one pending byte and a newer byte overwrites it.
module joypad_uart #(
    parameter logic [15:0] ADDR         = 16'hFF00,
    parameter int          CLKS_PER_BIT = 9,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic        clockgb,
    input  logic        resetn,
    input  logic [15:0] address,
    input  logic [7:0]  indata,
    output logic [7:0]  outdata,
    input  logic        load,
    input  logic        store,
    output logic        joy_int,
    input  logic        UART_RX,
    output logic        UART_TX
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [7:0] BIT_LAST  = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] HALF_LAST = 8'(CLKS_PER_BIT / 2 - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_s;

    logic [1:0] rx_state_q, rx_state_d;
    logic [7:0] rx_baud_q, rx_baud_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic       rx_ferr_q, rx_ferr_d;
    logic       rx_accept;

    logic [1:0] sel_q, sel_d;
    logic [7:0] buttons_q, buttons_d;
    logic [3:0] nib;
    logic [3:0] nib_prev_q, nib_prev_d;
    logic       joy_int_q, joy_int_d;
    logic       reg_hit;

    logic unused_indata;
    assign unused_indata = ^{indata[7:6], indata[3:0]};

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Receiver: counters restart on every state entry so each bit is timed from the start-bit midpoint.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], UART_RX};
        rx_state_d = rx_state_q;
        rx_baud_d  = rx_baud_q + 8'd1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_ferr_d  = rx_ferr_q;
        rx_accept  = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                rx_baud_d = 8'd0;
                rx_bit_d  = 3'd0;
                rx_ferr_d = 1'b0;
                if (!rx_s) rx_state_d = ST_START;
            end
            ST_START: begin
                if (rx_baud_q == HALF_LAST) begin
                    rx_baud_d  = 8'd0;
                    rx_state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_baud_q == BIT_LAST) begin
                    rx_baud_d  = 8'd0;
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_bit_d   = 3'd0;
                        rx_state_d = ST_STOP;
                    end
                end
            end
            default: begin
                if (rx_ferr_q) begin
                    rx_baud_d = 8'd0;
                    if (rx_s) rx_state_d = ST_IDLE;
                end else if (rx_baud_q == BIT_LAST) begin
                    rx_baud_d = 8'd0;
                    if (rx_s) begin
                        rx_accept  = 1'b1;
                        rx_state_d = ST_IDLE;
                    end else begin
                        rx_ferr_d = 1'b1;
                    end
                end
            end
        endcase
    end

    assign reg_hit = (address == ADDR);

    always_comb begin
        sel_d     = (store && reg_hit) ? indata[5:4] : sel_q;
        buttons_d = rx_accept ? rx_shift_q : buttons_q;
        nib       = 4'hF;
        if (!sel_q[0]) nib = nib & ~buttons_q[3:0];
        if (!sel_q[1]) nib = nib & ~buttons_q[7:4];
        nib_prev_d = nib;
        // Only falling nibble bits (new press or newly selected pressed key) interrupt.
        joy_int_d  = |(nib_prev_q & ~nib);
        outdata    = (load && reg_hit) ? {2'b11, sel_q, nib} : 8'hFF;
    end

    assign joy_int = joy_int_q;

    always_ff @(posedge clockgb) begin
        if (!resetn) begin
            sync_q     <= '1;
            rx_state_q <= ST_IDLE;
            rx_baud_q  <= 8'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'd0;
            rx_ferr_q  <= 1'b0;
            sel_q      <= 2'b11;
            buttons_q  <= 8'h00;
            nib_prev_q <= 4'hF;
            joy_int_q  <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            rx_state_q <= rx_state_d;
            rx_baud_q  <= rx_baud_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_ferr_q  <= rx_ferr_d;
            sel_q      <= sel_d;
            buttons_q  <= buttons_d;
            nib_prev_q <= nib_prev_d;
            joy_int_q  <= joy_int_d;
        end
    end

`ifdef JOYPAD_TX_ECHO_EN
    logic [1:0] tx_state_q, tx_state_d;
    logic [7:0] tx_baud_q, tx_baud_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       tx_q, tx_d;
    logic       pend_vld_q, pend_vld_d;
    logic [7:0] pend_q, pend_d;
    logic       pend_take;

    // Echo transmitter: chains straight from STOP into START when a byte is pending.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_baud_d  = tx_baud_q + 8'd1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        pend_take  = 1'b0;
        case (tx_state_q)
            ST_IDLE: begin
                tx_baud_d = 8'd0;
                tx_bit_d  = 3'd0;
                if (pend_vld_q) begin
                    tx_state_d = ST_START;
                    tx_shift_d = pend_q;
                    pend_take  = 1'b1;
                end
            end
            ST_START: begin
                if (tx_baud_q == BIT_LAST) begin
                    tx_baud_d  = 8'd0;
                    tx_state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tx_baud_q == BIT_LAST) begin
                    tx_baud_d  = 8'd0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_bit_d   = 3'd0;
                        tx_state_d = ST_STOP;
                    end
                end
            end
            default: begin
                if (tx_baud_q == BIT_LAST) begin
                    tx_baud_d = 8'd0;
                    if (pend_vld_q) begin
                        tx_state_d = ST_START;
                        tx_shift_d = pend_q;
                        pend_take  = 1'b1;
                    end else begin
                        tx_state_d = ST_IDLE;
                    end
                end
            end
        endcase
        pend_vld_d = rx_accept ? 1'b1 : (pend_take ? 1'b0 : pend_vld_q);
        pend_d     = rx_accept ? rx_shift_q : pend_q;
        case (tx_state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = tx_shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clockgb) begin
        if (!resetn) begin
            tx_state_q <= ST_IDLE;
            tx_baud_q  <= 8'd0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'd0;
            tx_q       <= 1'b1;
            pend_vld_q <= 1'b0;
            pend_q     <= 8'd0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            pend_vld_q <= pend_vld_d;
            pend_q     <= pend_d;
        end
    end

    assign UART_TX = tx_q;
`else
    assign UART_TX = 1'b1;
`endif

endmodule

// File: tb/tb_joypad_uart.sv
// Directed bench for joypad_uart at CLKS_PER_BIT=8, SYNC_STAGES=2; echo frames checked when JOYPAD_TX_ECHO_EN is defined.
module tb_joypad_uart;
    localparam int CPB = 8;

    logic        clockgb = 1'b0;
    logic        resetn  = 1'b0;
    logic [15:0] address = 16'h0000;
    logic [7:0]  indata  = 8'h00;
    logic [7:0]  outdata;
    logic        load    = 1'b0;
    logic        store   = 1'b0;
    logic        joy_int;
    logic        UART_RX = 1'b1;
    logic        UART_TX;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   int_cnt  = 0;
    int   int_base = 0;
    int   cyc      = 0;
    logic tx_low_seen = 1'b0;

    joypad_uart #(
        .ADDR        (16'hFF00),
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (2)
    ) dut (
        .clockgb(clockgb),
        .resetn (resetn),
        .address(address),
        .indata (indata),
        .outdata(outdata),
        .load   (load),
        .store  (store),
        .joy_int(joy_int),
        .UART_RX(UART_RX),
        .UART_TX(UART_TX)
    );

    always #5 clockgb = ~clockgb;

    always @(posedge clockgb) cyc++;

    always @(negedge clockgb) begin
        if (joy_int === 1'b1) int_cnt++;
        if (resetn && UART_TX !== 1'b1) tx_low_seen = 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clockgb);
    endtask

    task automatic cpu_write(input logic [7:0] v);
        @(negedge clockgb);
        address = 16'hFF00;
        indata  = v;
        store   = 1'b1;
        @(negedge clockgb);
        store   = 1'b0;
        address = 16'h0000;
    endtask

    task automatic cpu_read(input string tag, input logic [15:0] a, input logic ld, input logic [7:0] exp);
        @(negedge clockgb);
        address = a;
        load    = ld;
        #1;
        check_eq(tag, {24'd0, outdata}, {24'd0, exp});
        load    = 1'b0;
        address = 16'h0000;
    endtask

    task automatic drive_bit(input logic v);
        @(negedge clockgb);
        UART_RX = v;
        repeat (CPB - 1) @(negedge clockgb);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
        if (!stop_bit) begin
            @(negedge clockgb);
            UART_RX = 1'b1;
        end
    endtask

    task automatic mark_int();
        int_base = int_cnt;
    endtask

    task automatic check_int(input string tag, input int exp);
        check_eq(tag, int_cnt - int_base, exp);
    endtask

`ifdef JOYPAD_TX_ECHO_EN
    task automatic grab_tx(output logic [7:0] b, output int t0, output logic ok,
                           output logic st, output logic sp);
        ok = 1'b0;
        b  = 8'h00;
        st = 1'b1;
        sp = 1'b0;
        t0 = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clockgb);
            if (UART_TX === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        t0 = cyc;
        if (ok) begin
            repeat (CPB / 2) @(negedge clockgb);
            st = UART_TX;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clockgb);
                b[i] = UART_TX;
            end
            repeat (CPB) @(negedge clockgb);
            sp = UART_TX;
        end
    endtask
`endif

    initial begin
        tick(4);
        check_eq("rst_joy_int", {31'd0, joy_int}, 32'd0);
        check_eq("rst_uart_tx", {31'd0, UART_TX}, 32'd1);
        @(negedge clockgb);
        resetn = 1'b1;
        mark_int();
        cpu_read("rst_read", 16'hFF00, 1'b1, 8'hFF);
        cpu_read("other_addr", 16'hFF01, 1'b1, 8'hFF);
        cpu_read("no_load", 16'hFF00, 1'b0, 8'hFF);
        tick(3);
        check_int("rst_no_int", 0);

        // Direction row selected, press bit 0.
        cpu_write(8'h20);
        cpu_read("sel10_idle", 16'hFF00, 1'b1, 8'hEF);
        mark_int();
        send_frame(8'h01, 1'b1);
        tick(12);
        cpu_read("btn01_read", 16'hFF00, 1'b1, 8'hEE);
        check_int("btn01_int", 1);

        // Action press while direction row selected: nibble releases, no interrupt.
        mark_int();
        send_frame(8'h10, 1'b1);
        tick(12);
        cpu_read("btn10_read", 16'hFF00, 1'b1, 8'hEF);
        check_int("btn10_no_int", 0);
        mark_int();
        cpu_write(8'h10);
        tick(3);
        cpu_read("sel01_read", 16'hFF00, 1'b1, 8'hDE);
        check_int("sel01_int", 1);

        // Three-cycle low glitch is rejected.
        mark_int();
        @(negedge clockgb);
        UART_RX = 1'b0;
        tick(3);
        UART_RX = 1'b1;
        tick(20);
        cpu_read("glitch_read", 16'hFF00, 1'b1, 8'hDE);
        check_int("glitch_no_int", 0);

        // Framing error discards, next good frame accepted.
        mark_int();
        send_frame(8'h0F, 1'b0);
        tick(12);
        cpu_read("ferr_read", 16'hFF00, 1'b1, 8'hDE);
        check_int("ferr_no_int", 0);
        send_frame(8'h0F, 1'b1);
        tick(12);
        cpu_read("after_ferr_read", 16'hFF00, 1'b1, 8'hDF);
        check_int("after_ferr_no_int", 0);

        // Both rows selected: all four nibble bits fall together, one pulse.
        mark_int();
        cpu_write(8'h00);
        tick(3);
        cpu_read("sel00_read", 16'hFF00, 1'b1, 8'hC0);
        check_int("sel00_int", 1);

        mark_int();
        send_frame(8'h0F, 1'b1);
        tick(12);
        cpu_read("repeat_read", 16'hFF00, 1'b1, 8'hC0);
        check_int("repeat_no_int", 0);

        mark_int();
        send_frame(8'h00, 1'b1);
        tick(12);
        cpu_read("release_read", 16'hFF00, 1'b1, 8'hCF);
        check_int("release_no_int", 0);

        // Reset mid-frame, then a fresh frame is received normally.
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        @(negedge clockgb);
        resetn  = 1'b0;
        UART_RX = 1'b1;
        tick(3);
        resetn = 1'b1;
        mark_int();
        tick(20);
        cpu_read("midrst_read", 16'hFF00, 1'b1, 8'hFF);
        check_int("midrst_no_int", 0);
        cpu_write(8'h20);
        send_frame(8'h02, 1'b1);
        tick(12);
        cpu_read("postrst_read", 16'hFF00, 1'b1, 8'hED);
        check_int("postrst_int", 1);

`ifdef JOYPAD_TX_ECHO_EN
        begin
            logic [7:0] b1, b2;
            int         t1, t2;
            logic       ok1, ok2, s1, s2, p1, p2;
            tick(200);
            fork
                begin
                    send_frame(8'hA5, 1'b1);
                    send_frame(8'h3C, 1'b1);
                end
                begin
                    grab_tx(b1, t1, ok1, s1, p1);
                    grab_tx(b2, t2, ok2, s2, p2);
                end
            join
            check_eq("echo1_seen", {31'd0, ok1}, 32'd1);
            check_eq("echo1_byte", {24'd0, b1}, 32'hA5);
            check_eq("echo1_start", {31'd0, s1}, 32'd0);
            check_eq("echo1_stop", {31'd0, p1}, 32'd1);
            check_eq("echo2_seen", {31'd0, ok2}, 32'd1);
            check_eq("echo2_byte", {24'd0, b2}, 32'h3C);
            check_eq("echo2_stop", {31'd0, p2}, 32'd1);
            check_eq("echo_frame_cycles", t2 - t1, 32'd80);
        end
`else
        check_eq("tx_idle_high", {31'd0, tx_low_seen}, 32'd0);
`endif

        tick(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/joypad_uart.md
JOYPAD_UART -- requirements
Module: joypad_uart

Interface
REQ-001 Parameter ADDR, default 16'hFF00, memory-mapped address of the joypad register.
REQ-002 Parameter CLKS_PER_BIT, default 9, clockgb cycles per UART bit; legal range 4..255.
REQ-003 Parameter SYNC_STAGES, default 2, flip-flops on UART_RX before use; legal range 2..4.
REQ-004 clockgb  in  1  sole clock; all state on rising edge.
REQ-005 resetn  in  1  reset, synchronous, active-low.
REQ-006 address  in  16  CPU address.
REQ-007 indata  in  8  CPU write data.
REQ-008 outdata  out  8  CPU read data, combinational.
REQ-009 load  in  1  CPU read strobe.
REQ-010 store  in  1  CPU write strobe, one cycle per write.
REQ-011 joy_int  out  1  joypad interrupt request, one-cycle pulse.
REQ-012 UART_RX  in  1  asynchronous serial input, idle high.
REQ-013 UART_TX  out  1  serial output, idle high.

Function
REQ-014 Register state: sel[1:0] (written select bits), buttons[7:0] (1 = pressed; [3:0] direction, [7:4] action).
REQ-015 nib[3:0] = 4'hF, AND ~buttons[3:0] when sel[0]==0, AND ~buttons[7:4] when sel[1]==0 (active-low select, as on hardware).
REQ-016 outdata = {2'b11, sel, nib} when load && address==ADDR; otherwise 8'hFF.
REQ-017 store && address==ADDR: sel <= indata[5:4] next edge; other bits ignored.
REQ-018 UART_RX passes through SYNC_STAGES flops; receiver sees rx_s only.
REQ-019 Receiver FSM, 8N1, LSB first: IDLE -> START on rx_s==0.
REQ-020 START: at CLKS_PER_BIT/2 cycles, rx_s==0 -> DATA, else IDLE (glitch rejected, nothing latched).
REQ-021 DATA: sample each bit every CLKS_PER_BIT cycles from start mid-point; after 8th bit -> STOP.
REQ-022 STOP: sample after CLKS_PER_BIT; 1 -> buttons <= byte, return IDLE; 0 -> framing error, byte discarded, wait in STOP until rx_s==1, then IDLE.
REQ-023 Bit counter 3 bits, baud counter 8 bits; both clear on every state entry.
REQ-024 joy_int pulses high exactly one cycle when any nib bit goes 1->0 between consecutive cycles, from a button update, a sel write, or both.
REQ-025 Button update and sel write in the same cycle: both take effect; at most one joy_int pulse.
REQ-026 nib 0->1 transitions (release, deselect) never raise joy_int.
REQ-027 Identical byte received again: buttons unchanged, no joy_int.
REQ-028 Latency: buttons update the edge after the stop-bit sample; joy_int asserted the following edge.

Reset
REQ-029 resetn==0 at an edge: sel=2'b11, buttons=8'h00, joy_int=0, RX FSM IDLE, counters 0, sync flops 1, UART_TX=1.
REQ-030 Reset mid-frame aborts the frame; no partial byte reaches buttons; next frame received normally.
REQ-031 No joy_int on the first cycle after reset release.

Configuration
REQ-032 Macro JOYPAD_TX_ECHO_EN defined: a second FSM (IDLE, START, DATA, STOP) retransmits every accepted byte on UART_TX at CLKS_PER_BIT, 8N1, LSB first.
REQ-033 Echo busy when a new byte is accepted: the new byte is held in a one-entry pending register and sent next; a third byte overwrites the pending one.
REQ-034 Framing-error bytes are never echoed.
REQ-035 Macro not defined: UART_TX tied to 1, no TX logic instantiated.

Verification (CLKS_PER_BIT=8, SYNC_STAGES=2)
REQ-036 Reset, read FF00 -> outdata 8'hFF; joy_int never high.
REQ-037 Write 8'h20 (sel=10), send byte 8'h01 -> buttons 8'h01, read 8'hEE, one joy_int pulse.
REQ-038 Send 8'h10 with sel=10 -> nib 4'hF, no joy_int; write 8'h10 -> nib 4'hE, one joy_int pulse.
REQ-039 3-cycle low glitch on UART_RX -> FSM back in IDLE, buttons unchanged, no joy_int.
REQ-040 Frame 8'h0F with stop bit 0 -> buttons unchanged, no joy_int; next valid 8'h0F accepted.
REQ-041 JOYPAD_TX_ECHO_EN: send 8'hA5 then 8'h3C back-to-back -> UART_TX carries 8'hA5 then 8'h3C, 80 cycles per frame.
